// File: rtl/fetch_pkg.sv
// Shared types and target arithmetic for the instruction fetch stage.
// Combinational helpers only; no latency.
// No flow control; consumers decide when targets are used.
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pc_src_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Branch target: delay-slot address plus sign-extended word offset.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_ex,
                                                input logic [15:0] imm);
    logic [31:0] offset;
    offset = {{14{imm[15]}}, imm, 2'b00};
    return pc_ex + 32'd4 + offset;
  endfunction

  // Jump target: region bits of the delay-slot address, 26-bit index shifted.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_ex,
                                              input logic [31:0] instr);
    logic [31:0] pc_plus4;
    pc_plus4 = pc_ex + 32'd4;
    return (pc_plus4 & 32'hF000_0000) | ((instr << 2) & 32'h0FFF_FFFC);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage (sequential, branch, jump, register jump).
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the result is loaded.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [31:0] pc_F,
  input  logic [31:0] pc_EX,
  input  logic [31:0] instruction_EX,
  input  logic [31:0] rs_data_EX,
  input  pc_src_t     pc_src_EX,
  output logic [31:0] next_pc
);

  // Pick the target from the instruction currently in EX; low bits always cleared.
  always_comb begin
    next_pc = pc_F + 32'd4;
    unique case (pc_src_EX)
      PC_SEQ:    next_pc = pc_F + 32'd4;
      PC_BRANCH: next_pc = branch_target(pc_EX, instruction_EX[15:0]);
      PC_JUMP:   next_pc = jump_target(pc_EX, instruction_EX);
      PC_JR:     next_pc = rs_data_EX & 32'hFFFF_FFFC;
      default:   next_pc = pc_F + 32'd4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, registers the fetched instruction into EX. Optional FETCH_PERF_CNT_EN adds counters.
// Latency: one cycle imem_addr -> instruction_EX; redirects reach imem_addr one cycle later.
// run=0 freezes all state; stall_FETCH injects a NOP bubble and holds the PC unless redirected.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall_FETCH,
  input  logic [1:0]         pc_src_EX,
  input  logic [31:0]        rs_data_EX,
  output logic [31:0]        instruction_EX,
  output logic [31:0]        pc_EX,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        fetch_count,
  output logic [31:0]        bubble_count,
`endif
  output logic               valid_EX
);

  logic [31:0] pc_F;
  logic [31:0] target_pc;
  logic        hold_pc;

  assign imem_addr = pc_F[IMEM_AW+1:2];

  fetch_next_pc u_next_pc (
    .pc_F           (pc_F),
    .pc_EX          (pc_EX),
    .instruction_EX (instruction_EX),
    .rs_data_EX     (rs_data_EX),
    .pc_src_EX      (pc_src_t'(pc_src_EX)),
    .next_pc        (target_pc)
  );

  // A pure bubble (squash without redirect) re-fetches the same address.
  assign hold_pc = stall_FETCH && (pc_src_EX == PC_SEQ);

  // PC and EX pipeline registers; a squash replaces the fetched word with a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_F           <= RESET_PC;
      instruction_EX <= NOP_INSTR;
      pc_EX          <= 32'h0;
      valid_EX       <= 1'b0;
    end else if (run) begin
      pc_F           <= hold_pc ? pc_F : target_pc;
      instruction_EX <= stall_FETCH ? NOP_INSTR : imem_rdata;
      pc_EX          <= pc_F;
      valid_EX       <= !stall_FETCH;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count each advancing cycle as either a real fetch or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count  <= 32'h0;
      bubble_count <= 32'h0;
    end else if (run) begin
      if (!stall_FETCH) fetch_count  <= fetch_count + 32'd1;
      else              bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule
